pow_seq: RTL and testbench

//   Sequential integer power unit: computes y = x^e for an unsigned base and a runtime exponent.
//   It is the parametrised successor of the fixed-cube datapath, with configurable base,

---
 rtl/pow_seq.sv | 149 ++++++++++++++
 tb/tb_pow_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pow_seq.sv
// +------------------------------------------------------------------+
// | pow_seq : sequential unsigned power y = x^e, shift-add multiply  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module pow_seq #(
  parameter int X_W = 8,
  parameter int E_W = 3,
  parameter int Y_W = 24
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [X_W-1:0] x_bi,
  input  logic [E_W-1:0] e_bi,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           ovf_o,
  output logic [Y_W-1:0] y_bo
);

  localparam int P_W = Y_W + X_W;
  localparam int C_W = (X_W > 1) ? $clog2(X_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [X_W-1:0] xr_q, xr_d;
  logic [E_W-1:0] er_q, er_d;
  logic [C_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0] mcand_q, mcand_d;
  logic [X_W-1:0] mplr_q, mplr_d;
  logic [P_W-1:0] prod_q, prod_d;
  logic           sovf_q, sovf_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           ovf_q, ovf_d;
  logic           done_q, done_d;

  logic [P_W-1:0] w_sum;
  logic           w_last_bit;
  logic           w_ovf_new;

  // mcand_q carries the running accumulator, shifted left one place per cycle
  assign w_sum      = prod_q + (mplr_q[0] ? mcand_q : {P_W{1'b0}});
  assign w_last_bit = (cnt_q == C_W'(X_W - 1));
  assign w_ovf_new  = sovf_q | (|w_sum[P_W-1:Y_W]);

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    er_d    = er_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    prod_d  = prod_q;
    sovf_d  = sovf_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          xr_d    = x_bi;
          er_d    = e_bi;
          cnt_d   = '0;
          mcand_d = P_W'(1);
          mplr_d  = x_bi;
          prod_d  = '0;
          sovf_d  = 1'b0;
          if (e_bi == '0) begin
            state_d = S_DONE;
            y_d     = Y_W'(1);
            ovf_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        prod_d  = w_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + C_W'(1);
        if (w_last_bit) begin
          mcand_d = P_W'(w_sum[Y_W-1:0]);
          mplr_d  = xr_q;
          prod_d  = '0;
          cnt_d   = '0;
          sovf_d  = w_ovf_new;
          er_d    = er_q - E_W'(1);
          if (er_q == E_W'(1)) begin
            state_d = S_DONE;
            y_d     = w_sum[Y_W-1:0];
            ovf_d   = w_ovf_new;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      xr_q    <= '0;
      er_q    <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      prod_q  <= '0;
      sovf_q  <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      er_q    <= er_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      prod_q  <= prod_d;
      sovf_q  <= sovf_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == S_MUL);
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign y_bo   = y_q;

endmodule

`default_nettype wire

// File: tb/tb_pow_seq.sv
// +------------------------------------------------------------------+
// | tb_pow_seq : directed + random checks of pow_seq vs x^e model    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_pow_seq;

  localparam int X_W = 8;
  localparam int E_W = 3;
  localparam int Y_W = 24;

  logic           clk;
  logic           rst;
  logic [X_W-1:0] x;
  logic [E_W-1:0] e;
  logic           start;
  logic           busy;
  logic           done;
  logic           ovf;
  logic [Y_W-1:0] y;

  int n_checks = 0;
  int n_pass   = 0;

  pow_seq #(.X_W(X_W), .E_W(E_W), .Y_W(Y_W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .x_bi   (x),
    .e_bi   (e),
    .start_i(start),
    .busy_o (busy),
    .done_o (done),
    .ovf_o  (ovf),
    .y_bo   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Starts x^e, optionally pokes a bogus start while busy, and watches
  // e*X_W+tail cycles after the accepting edge.
  task automatic run_op(input logic [X_W-1:0] xv, input logic [E_W-1:0] ev,
                        input int tail, input bit poke, input string tag);
    longint unsigned tv;
    int lat, busy_cnt, done_at, done_cnt;
    logic [Y_W-1:0] y_at;
    logic ovf_at;
    tv = 1;
    for (int i = 0; i < int'(ev); i++) tv = tv * longint'(xv);
    lat      = int'(ev) * X_W;
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    y_at     = '0;
    ovf_at   = 1'b0;
    @(negedge clk);
    x = xv; e = ev; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    x = $urandom(); e = $urandom();
    for (int n = 0; n <= lat + tail; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = n;
          y_at    = y;
          ovf_at  = ovf;
        end
      end
      if (poke && n == 4) begin
        start = 1'b1; x = 8'd9; e = 3'd5;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, " latency"}, longint'(done_at), longint'(lat));
    chk({tag, " done_cnt"}, longint'(done_cnt), 1);
    chk({tag, " busy_cnt"}, longint'(busy_cnt), longint'(lat));
    chk({tag, " y"}, longint'(y_at), tv % (64'd1 << Y_W));
    chk({tag, " ovf"}, longint'(ovf_at), (tv >= (64'd1 << Y_W)) ? 1 : 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; x = '0; e = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset y", longint'(y), 0);
    chk("reset ovf", longint'(ovf), 0);
    rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (y !== '0 || ovf !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("idle outputs", longint'(bad), 0);

    run_op(8'd5,   3'd3, 2, 1'b0, "5^3");
    run_op(8'd255, 3'd3, 2, 1'b0, "255^3");
    run_op(8'd255, 3'd4, 2, 1'b0, "255^4");
    run_op(8'd0,   3'd0, 2, 1'b0, "0^0");
    run_op(8'd2,   3'd7, 2, 1'b0, "2^7");
    run_op(8'd3,   3'd2, 0, 1'b1, "3^2 poke");
    run_op(8'd6,   3'd2, 2, 1'b0, "restart 6^2");
    run_op(8'd0,   3'd5, 2, 1'b0, "0^5");
    run_op(8'd1,   3'd7, 2, 1'b0, "1^7");
    run_op(8'd16,  3'd6, 2, 1'b0, "16^6");

    // Abort mid-operation with reset
    @(negedge clk);
    x = 8'd7; e = 3'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort busy", longint'(busy), 0);
    chk("abort done", longint'(done), 0);
    chk("abort y", longint'(y), 0);
    chk("abort ovf", longint'(ovf), 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abort quiet", longint'(bad), 0);
    run_op(8'd2, 3'd1, 2, 1'b0, "2^1 after abort");

    for (int i = 0; i < 20; i++) begin
      run_op(X_W'($urandom_range(0, 255)), E_W'($urandom_range(0, 7)),
             $urandom_range(0, 2), 1'b0, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
